output_argmax_trainer: RTL

- Downstream consumer of the 35-neuron learning layer's outputs (`out[34:0]`).
- Captures one output vector together with its ground-truth label and finds the winning class with a sequential argmax scan.
- Reports the prediction and keeps accuracy statistics.
- In training mode, drives the one-hot `expected_out` vector and a one-cycle `learn` strobe back into the layer.

---
 rtl/output_argmax_trainer_pkg.sv | 19 +
 rtl/output_argmax_trainer_if.sv | 38 +++
 rtl/output_argmax_trainer_onehot_target.sv | 17 +
 rtl/output_argmax_trainer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/output_argmax_trainer_pkg.sv
// Shared definitions for the output-layer argmax/trainer blocks.
// zero2one_t is an unsigned fraction: 0 maps to 0.0 and all-ones to 1.0.
package output_argmax_trainer_pkg;

    localparam int FRAC_W = 8;

    typedef logic [FRAC_W-1:0] frac_t;
    typedef frac_t             zero2one_t;

    localparam zero2one_t ZERO2ONE_ZERO = '0;
    localparam zero2one_t ZERO2ONE_ONE  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        RESULT = 2'd2
    } argmax_state_t;

endpackage

// File: rtl/output_argmax_trainer_if.sv
// Sample/result bus between the learning layer, its label source and the
// argmax trainer. master = environment side, slave = trainer side.
interface output_argmax_trainer_if #(
    parameter int M     = 35,
    parameter int CNT_W = 16
);
    import output_argmax_trainer_pkg::*;

    localparam int IW = $clog2(M);

    logic                  in_valid;
    logic                  in_ready;
    zero2one_t [M-1:0]     layer_out;
    logic      [IW-1:0]    label;
    logic                  train;
    zero2one_t [M-1:0]     expected_out;
    logic                  learn;
    logic                  res_valid;
    logic                  res_ready;
    logic      [IW-1:0]    pred;
    logic                  correct;
    zero2one_t             margin;
    logic      [CNT_W-1:0] sample_count;
    logic      [CNT_W-1:0] correct_count;

    modport master (
        output in_valid, layer_out, label, train, res_ready,
        input  in_ready, expected_out, learn, res_valid, pred, correct,
               margin, sample_count, correct_count
    );

    modport slave (
        input  in_valid, layer_out, label, train, res_ready,
        output in_ready, expected_out, learn, res_valid, pred, correct,
               margin, sample_count, correct_count
    );

endinterface

// File: rtl/output_argmax_trainer_onehot_target.sv
// onehot_target: label -> one-hot zero2one_t target vector (combinational).
// A label outside 0..M-1 produces an all-ZERO vector.
module onehot_target
    import output_argmax_trainer_pkg::*;
#(
    parameter int M  = 35,
    parameter int IW = $clog2(M)
) (
    input  logic      [IW-1:0] label,
    output zero2one_t [M-1:0]  target
);

    for (genvar k = 0; k < M; k++) begin : g_lane
        assign target[k] = (label == IW'(k)) ? ZERO2ONE_ONE : ZERO2ONE_ZERO;
    end

endmodule

// File: rtl/output_argmax_trainer.sv
// output_argmax_trainer: captures one layer output vector plus label, finds
// the winning class with a one-element-per-cycle argmax scan, reports the
// prediction, keeps saturating accuracy counters and, in training mode,
// drives a one-hot target and a one-cycle learn strobe back to the layer.
// Optional: define ARGMAX_MARGIN_EN to also track the runner-up and report
// margin = top1 - top2; otherwise margin is tied to ZERO.
module output_argmax_trainer
    import output_argmax_trainer_pkg::*;
#(
    parameter int M     = 35,
    parameter int CNT_W = 16
) (
    input logic                    clock,
    input logic                    reset,
    output_argmax_trainer_if.slave bus
);

    localparam int IW = $clog2(M);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_SCAN   = SCAN;
    localparam logic [1:0] S_RESULT = RESULT;

    logic [1:0]        state;
    logic              in_ready_q;
    logic              res_valid_q;
    logic              learn_q;
    logic [IW-1:0]     pred_q;
    logic              correct_q;
    zero2one_t         margin_q;
    logic [CNT_W-1:0]  sample_cnt;
    logic [CNT_W-1:0]  correct_cnt;
    zero2one_t [M-1:0] expected_q;

    // capture registers
    zero2one_t [M-1:0] layer_q;
    logic [IW-1:0]     label_q;
    logic              train_q;

    // scan state
    logic [IW-1:0]     idx;
    logic [IW-1:0]     best_idx;
    zero2one_t         best_val;

    zero2one_t [M-1:0] target;
    zero2one_t         cur;
    logic              take;
    logic [IW-1:0]     nxt_idx;
    zero2one_t         nxt_val;
    zero2one_t         margin_nxt;
    logic              hit;

    onehot_target #(.M(M), .IW(IW)) u_target (
        .label  (bus.label),
        .target (target)
    );

    // one scan step; the last step is folded straight into the result
    // registers so the result appears M cycles after the accept cycle
    assign cur     = layer_q[idx];
    assign take    = cur > best_val;
    assign nxt_idx = take ? idx : best_idx;
    assign nxt_val = take ? cur : best_val;
    assign hit     = (nxt_idx == label_q);

`ifdef ARGMAX_MARGIN_EN
    zero2one_t second_val;
    zero2one_t nxt_second;

    // runner-up: displaced best on an update, else the larger of the two
    assign nxt_second = take ? best_val : ((cur > second_val) ? cur : second_val);
    assign margin_nxt = nxt_val - nxt_second;

    // runner-up register, restarted at ZERO on each accepted sample
    always_ff @(posedge clock) begin
        if (reset) begin
            second_val <= ZERO2ONE_ZERO;
        end else if (state == S_IDLE) begin
            second_val <= ZERO2ONE_ZERO;
        end else if (state == S_SCAN) begin
            second_val <= nxt_second;
        end
    end
`else
    assign margin_nxt = ZERO2ONE_ZERO;
`endif

    // control FSM: IDLE accept -> SCAN (M-1 cycles) -> RESULT until handshake
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            learn_q     <= 1'b0;
            pred_q      <= '0;
            correct_q   <= 1'b0;
            margin_q    <= ZERO2ONE_ZERO;
            sample_cnt  <= '0;
            correct_cnt <= '0;
            expected_q  <= '0;
            layer_q     <= '0;
            label_q     <= '0;
            train_q     <= 1'b0;
            idx         <= '0;
            best_idx    <= '0;
            best_val    <= ZERO2ONE_ZERO;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        layer_q    <= bus.layer_out;
                        label_q    <= bus.label;
                        train_q    <= bus.train;
                        expected_q <= target;
                        in_ready_q <= 1'b0;
                        idx        <= IW'(1);
                        best_idx   <= '0;
                        best_val   <= bus.layer_out[0];
                        state      <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    best_idx <= nxt_idx;
                    best_val <= nxt_val;
                    if (idx == IW'(M - 1)) begin
                        state       <= S_RESULT;
                        pred_q      <= nxt_idx;
                        correct_q   <= hit;
                        margin_q    <= margin_nxt;
                        res_valid_q <= 1'b1;
                        learn_q     <= train_q;
                        if (sample_cnt != '1)
                            sample_cnt <= sample_cnt + CNT_W'(1);
                        if (hit && (correct_cnt != '1))
                            correct_cnt <= correct_cnt + CNT_W'(1);
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_RESULT: begin
                    learn_q <= 1'b0;
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.learn         = learn_q;
    assign bus.pred          = pred_q;
    assign bus.correct       = correct_q;
    assign bus.margin        = margin_q;
    assign bus.sample_count  = sample_cnt;
    assign bus.correct_count = correct_cnt;
    assign bus.expected_out  = expected_q;

endmodule
